// File: rtl/key_entry_buffer_if.sv
// Keypad entry bus: scanner-side inputs plus the entry buffer's results.
// The scanner (or a bench) drives through master; the entry buffer uses slave.
interface key_entry_buffer_if #(
    parameter int MAX_DIGITS = 4
);
    logic                    key_pressed;
    logic [3:0]              keyboardval;
    logic                    key_event;
    logic [3:0]              key_code;
    logic [4*MAX_DIGITS-1:0] digits;
    logic [2:0]              digit_cnt;
    logic [4*MAX_DIGITS-1:0] entry_value;
    logic                    entry_valid;
    logic                    overflow;

    modport master (
        output key_pressed, keyboardval,
        input  key_event, key_code, digits, digit_cnt,
               entry_value, entry_valid, overflow
    );

    modport slave (
        input  key_pressed, keyboardval,
        output key_event, key_code, digits, digit_cnt,
               entry_value, entry_valid, overflow
    );
endinterface

// File: rtl/key_entry_buffer.sv
// Keypad entry buffer: debounces each scanner press into a single key event,
// collects decimal digits into a BCD buffer and handles backspace/clear/enter.
module key_entry_buffer #(
    parameter int SETTLE_CYCLES = 1100000,
    parameter int MAX_DIGITS    = 4
) (
    input  logic                clk,
    input  logic                rst,
    key_entry_buffer_if.slave   bus
);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int DW    = 4 * MAX_DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [2:0]       CNT_FULL = 3'(MAX_DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        WAIT_RELEASE
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] settle_reg, settle_next;
    logic             sync1_reg, sync2_reg;
    logic             key_event_reg, key_event_next;
    logic [3:0]       key_code_reg, key_code_next;
    logic [DW-1:0]    digits_reg, digits_next;
    logic [2:0]       digit_cnt_reg, digit_cnt_next;
    logic [DW-1:0]    entry_value_reg, entry_value_next;
    logic             entry_valid_reg, entry_valid_next;
    logic             overflow_reg, overflow_next;

    // Two-flop synchronizer for the asynchronous press level from the scanner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= bus.key_pressed;
            sync2_reg <= sync1_reg;
        end
    end

    // State, settle counter and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            settle_reg      <= '0;
            key_event_reg   <= 1'b0;
            key_code_reg    <= 4'h0;
            digits_reg      <= '0;
            digit_cnt_reg   <= 3'd0;
            entry_value_reg <= '0;
            entry_valid_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            settle_reg      <= settle_next;
            key_event_reg   <= key_event_next;
            key_code_reg    <= key_code_next;
            digits_reg      <= digits_next;
            digit_cnt_reg   <= digit_cnt_next;
            entry_value_reg <= entry_value_next;
            entry_valid_reg <= entry_valid_next;
            overflow_reg    <= overflow_next;
        end
    end

    // Next-state logic plus the key action executed in the single CAPTURE cycle.
    always_comb begin
        state_next       = state_reg;
        settle_next      = settle_reg;
        key_event_next   = 1'b0;
        key_code_next    = key_code_reg;
        digits_next      = digits_reg;
        digit_cnt_next   = digit_cnt_reg;
        entry_value_next = entry_value_reg;
        entry_valid_next = 1'b0;
        overflow_next    = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (sync2_reg) begin
                    state_next  = SETTLE;
                    settle_next = '0;
                end
            end
            SETTLE: begin
                // Saturating count: stops at the last value rather than wrapping.
                if (settle_reg != CNT_LAST) begin
                    settle_next = settle_reg + 1'b1;
                end
                if (!sync2_reg) begin
                    state_next = IDLE;
                end else if (settle_reg == CNT_LAST) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                state_next     = WAIT_RELEASE;
                key_event_next = 1'b1;
                key_code_next  = bus.keyboardval;
                case (bus.keyboardval)
                    4'hE: begin
                        if (digit_cnt_reg != 3'd0) begin
                            digits_next    = {4'h0, digits_reg[DW-1:4]};
                            digit_cnt_next = digit_cnt_reg - 3'd1;
                        end
                    end
                    4'hC: begin
                        digits_next    = '0;
                        digit_cnt_next = 3'd0;
                    end
                    4'hF: begin
                        // An empty enter is ignored so entry_value keeps the last commit.
                        if (digit_cnt_reg != 3'd0) begin
                            entry_value_next = digits_reg;
                            entry_valid_next = 1'b1;
                            digits_next      = '0;
                            digit_cnt_next   = 3'd0;
                        end
                    end
                    4'hA, 4'hB, 4'hD: begin
                        // Reported as key events only; the buffer is untouched.
                    end
                    default: begin
                        if (digit_cnt_reg < CNT_FULL) begin
                            digits_next    = {digits_reg[DW-5:0], bus.keyboardval};
                            digit_cnt_next = digit_cnt_reg + 3'd1;
                        end else begin
                            overflow_next = 1'b1;
                        end
                    end
                endcase
            end
            WAIT_RELEASE: begin
                if (!sync2_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.key_event   = key_event_reg;
    assign bus.key_code    = key_code_reg;
    assign bus.digits      = digits_reg;
    assign bus.digit_cnt   = digit_cnt_reg;
    assign bus.entry_value = entry_value_reg;
    assign bus.entry_valid = entry_valid_reg;
    assign bus.overflow    = overflow_reg;
endmodule

// File: tb/tb_key_entry_buffer.sv
// Bench for key_entry_buffer: press sequences from the test plan plus a
// randomized run, checked against a queue-based model of the entry buffer.
module tb_key_entry_buffer;
    localparam int SETTLE = 4;
    localparam int MAXD   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    key_entry_buffer_if #(.MAX_DIGITS(MAXD)) bus ();

    key_entry_buffer #(.SETTLE_CYCLES(SETTLE), .MAX_DIGITS(MAXD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Model state: digits in entry order (oldest first) and last committed value.
    int          mq[$];
    logic [15:0] m_entry = 16'h0;

    // Observations gathered while a press is in progress.
    int   ev_n, ov_n, vl_n, first_ev;

    function automatic logic [15:0] model_digits();
        logic [15:0] v = 16'h0;
        foreach (mq[i]) v = v * 16 + 16'(mq[i]);
        return v;
    endfunction

    // Apply one key to the model; reports whether overflow / entry_valid should pulse.
    task automatic model_key(input int code, output int exp_ov, output int exp_vl);
        exp_ov = 0;
        exp_vl = 0;
        if (code <= 9) begin
            if (mq.size() < MAXD) mq.push_back(code);
            else exp_ov = 1;
        end else if (code == 14) begin
            if (mq.size() > 0) void'(mq.pop_back());
        end else if (code == 12) begin
            mq.delete();
        end else if (code == 15) begin
            if (mq.size() > 0) begin
                m_entry = model_digits();
                exp_vl  = 1;
                mq.delete();
            end
        end
    endtask

    // Drive one press held for 'hold' cycles, then release and let it settle.
    task automatic press(input logic [3:0] code, input int hold);
        @(negedge clk);
        bus.keyboardval = code;
        bus.key_pressed = 1'b1;
        ev_n = 0; ov_n = 0; vl_n = 0; first_ev = -1;
        for (int i = 0; i < hold + 8; i++) begin
            if (i == hold) begin
                @(negedge clk);
                bus.key_pressed = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.key_event) begin
                ev_n++;
                if (first_ev < 0) first_ev = i;
            end
            if (bus.overflow) ov_n++;
            if (bus.entry_valid) vl_n++;
        end
    endtask

    task automatic test_reset();
        bus.key_pressed = 1'b0;
        bus.keyboardval = 4'h0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.key_event, bus.key_code, bus.digits, bus.digit_cnt, bus.entry_value,
             bus.entry_valid, bus.overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ev=%b code=%h dig=%h cnt=%0d ent=%h vl=%b ov=%b want all 0",
                     bus.key_event, bus.key_code, bus.digits, bus.digit_cnt, bus.entry_value,
                     bus.entry_valid, bus.overflow);
        end
        @(negedge clk);
        rst = 1'b1;
        $display("reset released");
    endtask

    task automatic run_codes(input string name, input int codes[$], input int hold);
        int eo, ev;
        foreach (codes[k]) begin
            press(4'(codes[k]), hold);
            model_key(codes[k], eo, ev);
            $display("%s press %h: ev=%0d ov=%0d vl=%0d dig=%h cnt=%0d ent=%h",
                     name, codes[k], ev_n, ov_n, vl_n, bus.digits, bus.digit_cnt, bus.entry_value);
            checks++;
            if (ev_n !== 1 || bus.key_code !== 4'(codes[k])) begin
                errors++;
                $display("FAIL %s_event: got events=%0d code=%h want 1 code=%h", name, ev_n, bus.key_code, codes[k]);
            end
            checks++;
            if (bus.digits !== model_digits() || bus.digit_cnt !== 3'(mq.size())) begin
                errors++;
                $display("FAIL %s_buffer: got %h/%0d want %h/%0d", name, bus.digits, bus.digit_cnt,
                         model_digits(), mq.size());
            end
            checks++;
            if (ov_n !== eo || vl_n !== ev || bus.entry_value !== m_entry) begin
                errors++;
                $display("FAIL %s_pulses: got ov=%0d vl=%0d ent=%h want ov=%0d vl=%0d ent=%h",
                         name, ov_n, vl_n, bus.entry_value, eo, ev, m_entry);
            end
        end
    endtask

    task automatic test_digit_entry();
        run_codes("digit_enter", '{1, 2, 3, 15}, 20);
        checks++;
        if (m_entry !== 16'h0123 || bus.entry_value !== 16'h0123) begin
            errors++;
            $display("FAIL digit_enter_value: got %h want 0123", bus.entry_value);
        end
    endtask

    task automatic test_overflow();
        run_codes("overflow", '{9, 9, 9, 9, 9}, 20);
        checks++;
        if (bus.digits !== 16'h9999 || ov_n !== 1) begin
            errors++;
            $display("FAIL overflow_full: got dig=%h ov=%0d want 9999 ov=1", bus.digits, ov_n);
        end
    endtask

    task automatic test_backspace_clear();
        run_codes("bksp_clear", '{12, 4, 5, 14, 14, 14, 7, 12}, 15);
    endtask

    task automatic test_glitch_hold();
        @(negedge clk);
        bus.keyboardval = 4'h6;
        bus.key_pressed = 1'b1;
        repeat (3) @(negedge clk);
        bus.key_pressed = 1'b0;
        ev_n = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.key_event) ev_n++;
        end
        $display("glitch: events=%0d", ev_n);
        checks++;
        if (ev_n !== 0) begin
            errors++;
            $display("FAIL glitch_no_event: got %0d events want 0", ev_n);
        end
        run_codes("hold", '{7}, 200);
        checks++;
        if (first_ev !== SETTLE + 3) begin
            errors++;
            $display("FAIL hold_latency: got %0d cycles want %0d", first_ev, SETTLE + 3);
        end
    endtask

    task automatic test_noop_keys();
        run_codes("noop", '{12, 15, 3, 10, 11, 13}, 12);
    endtask

    task automatic test_reset_mid_settle();
        @(negedge clk);
        bus.keyboardval = 4'h5;
        bus.key_pressed = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        mq.delete();
        m_entry = 16'h0;
        checks++;
        if ({bus.key_event, bus.key_code, bus.digits, bus.digit_cnt, bus.entry_value,
             bus.entry_valid, bus.overflow} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got code=%h dig=%h cnt=%0d ent=%h want all 0",
                     bus.key_code, bus.digits, bus.digit_cnt, bus.entry_value);
        end
        @(negedge clk);
        bus.key_pressed = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ev_n = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.key_event) ev_n++;
        end
        $display("mid-settle reset: events after release=%0d", ev_n);
        checks++;
        if (ev_n !== 0) begin
            errors++;
            $display("FAIL midreset_no_event: got %0d events want 0", ev_n);
        end
    endtask

    task automatic test_random();
        int codes[$];
        int pick[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 14, 14, 12, 15, 15, 10};
        for (int k = 0; k < 40; k++) codes.push_back(pick[$urandom_range(0, 15)]);
        run_codes("random", codes, 6 + int'($urandom_range(0, 20)));
    endtask

    initial begin
        test_reset();
        test_digit_entry();
        test_overflow();
        test_backspace_clear();
        test_glitch_hold();
        test_noop_keys();
        test_reset_mid_settle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_entry_buffer.md
Name: key_entry_buffer

Overview:
- Consumes the 4x4 keypad scanner's output: the held 4-bit key code plus its key-pressed level flag.
- Turns each physical press into exactly one key event.
- Accumulates decimal digits into a BCD entry buffer and interprets command keys (backspace, clear, enter).
- Presents a live display value and a one-cycle committed-entry strobe to downstream logic, e.g. a calculator or lock controller and the seven-segment driver.

Parameters:
- SETTLE_CYCLES, 1100000: clk cycles to wait after the press flag rises before sampling the key code. Must exceed one scanner key_clk period (2^20 clk), because the scanner updates its code one key_clk after raising the flag.
- MAX_DIGITS, 4: BCD digit capacity of the entry buffer.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- key_pressed  input  1  scanner pressed flag, level, high while a key is held
- keyboardval  input  4  scanner key code, held value
- key_event  output  1  one-cycle pulse per accepted press
- key_code  output  4  code of the last accepted press
- digits  output  4*MAX_DIGITS  live BCD buffer; least-significant digit in bits [3:0]
- digit_cnt  output  3  number of digits currently held, 0..MAX_DIGITS
- entry_value  output  4*MAX_DIGITS  buffer contents latched at enter
- entry_valid  output  1  one-cycle pulse when entry_value updates
- overflow  output  1  one-cycle pulse when a digit is rejected because the buffer is full

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, FSM to IDLE, settle counter 0. Reset asserted mid-operation aborts everything; no event or strobe is emitted.
- Input sampling: key_pressed passes through a 2-flop synchronizer. keyboardval is registered once, sampled only in CAPTURE.
- FSM states: IDLE, SETTLE, CAPTURE, WAIT_RELEASE.
- IDLE: synchronized key_pressed high -> SETTLE, counter cleared.
- SETTLE:
  - counter increments each cycle;
  - key_pressed low -> IDLE (glitch, no event);
  - counter == SETTLE_CYCLES-1 -> CAPTURE.
- CAPTURE: lasts one cycle.
  - key_code <= keyboardval; key_event = 1.
  - The command action below executes in the same cycle; its outputs appear the next cycle alongside key_event.
  - -> WAIT_RELEASE.
- WAIT_RELEASE: stays until synchronized key_pressed low -> IDLE. A held key produces exactly one event; there is no auto-repeat.
- Latency: key_event is asserted SETTLE_CYCLES+3 clk after key_pressed rises (2 sync + settle + capture).
- Key actions:
  - 0x0-0x9, digit:
    - if digit_cnt < MAX_DIGITS: digits <= {digits shifted left 4, code}; digit_cnt+1.
    - else: buffer unchanged, overflow pulse.
  - 0xE, backspace: digits <= digits shifted right 4 (top digit 0); digit_cnt-1. No-op when digit_cnt == 0.
  - 0xC, clear: digits <= 0, digit_cnt <= 0. Always allowed.
  - 0xF, enter:
    - if digit_cnt > 0: entry_value <= digits; entry_valid pulse; buffer and count cleared.
    - if digit_cnt == 0: ignored; no pulse, entry_value unchanged.
  - 0xA, 0xB, 0xD: key_event and key_code update only; buffer untouched.
- Pulses: key_event, entry_valid and overflow are each high for exactly one clk and are mutually consistent. entry_valid and overflow only ever coincide with key_event.
- entry_value holds between enters.
- Width of the settle counter is ceil(log2(SETTLE_CYCLES)). It saturates and never wraps.

Test Plan (SETTLE_CYCLES=4, MAX_DIGITS=4):
1. Digit entry and enter: press 1, 2, 3, then F, each held 20 cycles -> digits 0x0123, digit_cnt 3. On F: entry_value 0x0123, entry_valid for 1 cycle, digits 0, digit_cnt 0.
2. Overflow: press 9 five times -> digits 0x9999, digit_cnt 4. Fifth press pulses overflow and leaves the buffer unchanged.
3. Backspace and clear:
   - 4, 5, E -> digits 0x0004, cnt 1.
   - E, E -> 0, cnt 0, no underflow.
   - 7, C -> 0.
4. Glitch and hold:
   - key_pressed high for 3 cycles -> no key_event.
   - Key held 200 cycles -> exactly one key_event, code latched 7 cycles after rise.
5. Empty enter and no-op keys: F with cnt 0 -> key_event only, no entry_valid. A, B, D -> key_code updates, digits unchanged.
6. Reset mid-settle: drop rst during SETTLE after pressing 5 -> all outputs 0. After release, no event from the aborted press.
